// File: rtl/isramsd_ctrl.sv
// rtl/isramsd_ctrl.sv - single-port SRAM macro access sequencer (precharge, wordline, sense/write, ack)
module isramsd_ctrl #(
    parameter int PRE_CYC = 1,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    addr,
    input  logic [DW-1:0] wdata,
    output logic          rdy,
    output logic [2:0]    dec_a,
    output logic          dec_en,
    output logic          pre,
    output logic          wr_en,
    output logic [DW-1:0] bl_din,
    output logic          sa_en,
    input  logic [DW-1:0] sa_dout,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          rvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACC,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [2:0]    lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured only on acceptance so later input changes cannot disturb the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 3'd0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                cnt       <= PRE_LOAD;
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end else if (state == S_PRE) begin
                cnt <= cnt - 4'd1;
            end
            if (state == S_XFER && !lat_we) begin
                rdata_q <= sa_dout;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        pre       = 1'b0;
        dec_en    = 1'b0;
        wr_en     = 1'b0;
        sa_en     = 1'b0;
        ack       = 1'b0;
        rvalid    = 1'b0;
        case (state)
            S_IDLE: begin
                rdy = 1'b1;
                if (req) begin
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                pre = 1'b1;
                // Last precharge cycle is the one entered with the counter at 1.
                if (cnt <= 4'd1) begin
                    state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                dec_en    = 1'b1;
                wr_en     = lat_we;
                state_nxt = S_XFER;
            end
            S_XFER: begin
                dec_en    = 1'b1;
                wr_en     = lat_we;
                sa_en     = !lat_we;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                ack       = 1'b1;
                rvalid    = !lat_we;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign dec_a  = lat_addr;
    assign bl_din = lat_wdata;
    assign rdata  = rdata_q;

endmodule

// File: doc/isramsd_ctrl.md
ISRAMSD_CTRL -- requirements
Module: isramsd_ctrl

Interface
REQ-001 Parameter PRE_CYC, default 1: precharge duration in clock cycles; legal range 1..15.
REQ-002 Parameter DW, default 32: data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req  input  1  access request valid.
REQ-006 we  input  1  access type; 1 = write, 0 = read; sampled with req.
REQ-007 addr  input  3  word address; sampled with req.
REQ-008 wdata  input  DW  write data; sampled with req.
REQ-009 rdy  output  1  controller idle, can accept req.
REQ-010 dec_a  output  3  address to row decoder a input.
REQ-011 dec_en  output  1  row decoder enable (wordline open).
REQ-012 pre  output  1  bitline precharge enable.
REQ-013 wr_en  output  1  write driver enable.
REQ-014 bl_din  output  DW  data to write drivers.
REQ-015 sa_en  output  1  sense amplifier enable.
REQ-016 sa_dout  input  DW  sense amplifier output.
REQ-017 rdata  output  DW  last read word.
REQ-018 ack  output  1  one-cycle access-complete pulse.
REQ-019 rvalid  output  1  one-cycle pulse, rdata newly valid (reads only).

Function
REQ-020 FSM states SHALL be IDLE, PRE, ACC, XFER, DONE; all control outputs decoded from registered state only (Moore, no input-to-output paths).
REQ-021 IDLE: rdy=1; req=1 at a rising edge SHALL latch addr, we, wdata and move to PRE; req=0 stays IDLE.
REQ-022 rdy SHALL be 0 in every state other than IDLE; req outside IDLE SHALL be ignored, not queued.
REQ-023 PRE: pre=1 for exactly PRE_CYC cycles via a 4-bit down-counter loaded on acceptance; then ACC.
REQ-024 ACC: dec_en=1, pre=0, wr_en=latched we, sa_en=0; one cycle; then XFER.
REQ-025 XFER: dec_en=1; read: sa_en=1 and rdata SHALL capture sa_dout on the edge leaving XFER; write: wr_en=1; one cycle; then DONE.
REQ-026 DONE: dec_en=0, ack=1, rvalid=latched !we; one cycle; then IDLE.
REQ-027 Latency: ack SHALL be high during cycle PRE_CYC+3 after the acceptance edge; throughput one access per PRE_CYC+4 cycles.
REQ-028 dec_a and bl_din SHALL equal the latched addr/wdata continuously and change only at acceptance.
REQ-029 rdata SHALL hold its value across writes and idle; updated only by a completed read.
REQ-030 Invariants: pre and dec_en never both 1; wr_en and sa_en never both 1; wr_en=1 only with dec_en=1.
REQ-031 Changes on addr/we/wdata after acceptance SHALL NOT affect the access in progress.
REQ-032 req held high continuously SHALL be accepted in each IDLE cycle, giving back-to-back accesses.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and rdy=1; pre, dec_en, wr_en, sa_en, ack, rvalid=0; dec_a=0; bl_din=0; rdata=0; counter=0.
REQ-034 Reset asserted mid-access SHALL abort the access with no ack; rdata SHALL be 0 and not updated.
REQ-035 First acceptance SHALL occur at the first rising edge with rst_n=1 and req=1.

Verification
REQ-036 Write: PRE_CYC=1, req=1, we=1, addr=5, wdata=32'hDEADBEEF -> pre 1 cycle, dec_a=5, dec_en 2 cycles, wr_en 2 cycles, bl_din=DEADBEEF, ack in cycle 4, rvalid=0, rdata unchanged.
REQ-037 Read: req, we=0, addr=3, sa_dout=32'h12345678 during XFER -> sa_en exactly 1 cycle, rdata=12345678 with rvalid=1 and ack=1 in same cycle.
REQ-038 PRE_CYC=4 read -> pre high exactly 4 cycles, ack in cycle 7, pre/dec_en never overlap.
REQ-039 Busy: second req with addr=7 asserted during PRE/ACC/XFER/DONE -> ignored, dec_a stays at first address; re-asserted in IDLE -> accepted.
REQ-040 Back-to-back: req held high, write addr=0 then read addr=0 -> accesses 5 cycles apart (PRE_CYC=1), rdata=write data looped from model.
REQ-041 Reset during XFER of a read -> all outputs at reset values asynchronously, no ack/rvalid pulse, next req accepted normally.
